alu_serial_ctrl: RTL and testbench

- Bit-serial sequencer for the team's 1-bit ALU slice: the slice output mux selects among MOV/NOT/ADD/NOR/SUB/NAND/AND/SLT with a 3-bit code.
- Latches a WIDTH-bit operation and drives the slice one bit per cycle, LSB first, carrying the carry between cycles.
- Assembles the result and flags and reports completion with a start/busy/done handshake.
- Sits between the register-file/control path and a single shared slice instance.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_serial_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: slice op codes and FSM state encoding.
package alu_pkg;

    // 3-bit select codes understood by the external 1-bit ALU slice
    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ops that run the slice as a subtractor (carry-in of 1 on bit 0)
    function automatic logic op_uses_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Ops whose carry/overflow flags are meaningful
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // SLT borrows the slice's subtract path; its own SLT code is never issued
    function automatic logic [2:0] slice_code(input logic [2:0] op);
        return (op == OP_SLT) ? OP_SUB : op;
    endfunction

endpackage

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer that drives a shared 1-bit ALU slice LSB first and
// assembles the WIDTH-bit result plus carry/overflow/zero flags.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_sel,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             run;
    logic             cin;
    logic             ovf_now;

    // Carry into the slice: forced on bit 0 (1 for subtract), chained afterwards
    always_comb begin
        run     = (state_q == ST_RUN);
        cin     = (cnt_q == '0) ? op_uses_sub(op_q) : cy_q;
        // On the MSB cycle cy_q is the carry into the MSB, so this is signed overflow
        ovf_now = op_is_arith(op_q) & (cy_q ^ slice_cout);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        op_d     = op_q;
        sel_d    = sel_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d  = ST_RUN;
                    op_d     = op;
                    sel_d    = slice_code(op);
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_sh_d = '0;
                    cnt_d    = '0;
                    cy_d     = 1'b0;
                end
            end
            ST_RUN: begin
                res_sh_d = {slice_out, res_sh_q[WIDTH-1:1]};
                cy_d     = slice_cout;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d  = ST_DONE;
                    ovf_d    = ovf_now;
                    carry_d  = op_is_arith(op_q) & slice_cout;
                    result_d = (op_q == OP_SLT)
                             ? {{(WIDTH-1){1'b0}}, slice_out ^ ovf_now}
                             : res_sh_d;
                    zero_d   = (result_d == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything including slice select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sel_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = run;
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign slice_a   = run & a_sh_q[0];
    assign slice_b   = run & b_sh_q[0];
    assign slice_cin = run & cin;
    assign slice_sel = sel_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: behavioural 1-bit slice, full-width
// reference model feeding a scoreboard queue, and cycle-exact handshake checks.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, carry, overflow, zero;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_cin, slice_out, slice_cout;
    logic [2:0]   slice_sel;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry),
        .overflow(overflow), .zero(zero),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_sel(slice_sel), .slice_out(slice_out), .slice_cout(slice_cout)
    );

    always #5 clk = ~clk;

    // Behavioural 1-bit slice with the team's select codes
    always_comb begin
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case (slice_sel)
            OP_MOV:  slice_out = slice_a;
            OP_NOT:  slice_out = ~slice_a;
            OP_ADD:  {slice_cout, slice_out} = {1'b0, slice_a} + {1'b0, slice_b} + {1'b0, slice_cin};
            OP_NOR:  slice_out = ~(slice_a | slice_b);
            OP_SUB:  {slice_cout, slice_out} = {1'b0, slice_a} + {1'b0, ~slice_b} + {1'b0, slice_cin};
            OP_NAND: slice_out = ~(slice_a & slice_b);
            OP_AND:  slice_out = slice_a & slice_b;
            default: slice_out = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Full-width reference for the expected result and flags
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W:0]   s;
        e = '0;
        s = '0;
        case (o)
            OP_MOV:  e.res = x;
            OP_NOT:  e.res = ~x;
            OP_NOR:  e.res = ~(x | y);
            OP_NAND: e.res = ~(x & y);
            OP_AND:  e.res = x & y;
            OP_ADD: begin
                s     = {1'b0, x} + {1'b0, y};
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
            end
            default: begin
                s     = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
                e.c   = s[W];
                e.v   = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
                e.res = (o == OP_SLT) ? {{(W-1){1'b0}}, ($signed(x) < $signed(y))} : s[W-1:0];
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Scoreboard: every done pops the oldest expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result",   result,   e.res);
                check("carry",    carry,    e.c);
                check("overflow", overflow, e.v);
                check("zero",     zero,     e.z);
            end
        end
    end

    // Drive a start for one edge; call away from the rising edge
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (push) sb_q.push_back(model(o, x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Walk the WIDTH busy cycles and the done cycle; optionally inject a stray start
    task automatic wait_done_timed(input logic [2:0] o, input int inject_at);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("busy_run", busy, 1'b1);
            check("done_run", done, 1'b0);
            if (i == 0) begin
                check("slice_sel", slice_sel, (o == OP_SLT) ? OP_SUB : o);
                check("slice_cin0", slice_cin, (o == OP_SUB || o == OP_SLT));
            end
            if (i == inject_at) begin
                start = 1'b1;
                op    = OP_AND;
                a     = 8'h3C;
                b     = 8'h3C;
            end
        end
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("busy_done", busy, 1'b0);
        check("slice_a_idle", slice_a, 1'b0);
        check("slice_cin_idle", slice_cin, 1'b0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        issue(o, x, y, 1'b1);
        wait_done_timed(o, -1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_result"}, result, '0);
        check({tag, "_flags"}, {carry, overflow, zero}, 3'b000);
        check({tag, "_slice"}, {slice_a, slice_b, slice_cin, slice_sel}, 6'd0);
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(OP_ADD, 8'h7F, 8'h01);
        run_op(OP_SUB, 8'h05, 8'h05);
        run_op(OP_SUB, 8'h80, 8'h01);
        run_op(OP_SLT, 8'hF0, 8'h05);
        run_op(OP_SLT, 8'h05, 8'hF0);
        run_op(OP_SLT, 8'h80, 8'h7F);
        run_op(OP_NOR,  8'hA5, 8'h0F);
        run_op(OP_NAND, 8'hA5, 8'h0F);
        run_op(OP_AND,  8'hA5, 8'h0F);
        run_op(OP_NOT,  8'hA5, 8'h0F);
        run_op(OP_MOV,  8'hA5, 8'h0F);

        // Result holds through IDLE
        @(negedge clk);
        check("hold_idle", result, 8'hA5);

        // Stray start in RUN is ignored
        @(negedge clk);
        issue(OP_ADD, 8'h12, 8'h34, 1'b1);
        wait_done_timed(OP_ADD, 3);

        // Back-to-back: start accepted in the DONE cycle
        issue(OP_SUB, 8'h10, 8'h20, 1'b1);
        wait_done_timed(OP_SUB, -1);
        issue(OP_ADD, 8'hFF, 8'h01, 1'b1);
        wait_done_timed(OP_ADD, -1);

        // Random back-to-back stream
        for (int k = 0; k < 6; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            issue(ro, ra, rb, 1'b1);
            wait_done_timed(ro, -1);
        end

        // Reset during bit 4 of an ADD: everything clears, no done follows
        run_op(OP_MOV, 8'hC3, 8'h00);
        @(negedge clk);
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("no_done_after_abort", done, 1'b0);
        end
        run_op(OP_ADD, 8'h01, 8'h01);

        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
